vector_element_sequencer: RTL
=============================

// Module: vector_element_sequencer
// PURPOSE
//  Sequences vector-unit element processing: on start, steps an element-group index
//  across a vector of vlen_i elements, LANES elements per issued group. Generates the
//  tail-lane mask, holds on stall, drains the datapath pipeline, then pulses done.
//  Sits between instruction decode and the vector lanes; decode drives it, lanes consume it.
// PARAMETERS
//  IDX_W  8  width of element index and vector length
//  LANES  4  elements per issued group (power of two, >=1)
//  LAT    2  datapath pipeline depth in cycles, waited out after the last issue (>=0)
// PORTS
//  clk      in   1      clock, all state on rising edge
//  rst      in   1      asynchronous, active-high reset
//  start_i  in   1      start request; accepted only in IDLE
//  vlen_i   in   IDX_W  element count, sampled with an accepted start; 0 is legal
//  stall_i  in   1      lanes cannot accept a group this cycle
//  busy_o   out  1      1 in every state except IDLE
//  valid_o  out  1      group issued this cycle (idx_o/mask_o/last_o valid)
//  idx_o    out  IDX_W  base element index of the current group
//  mask_o   out  LANES  lane enable; bit k = (idx_o + k < vlen)
//  last_o   out  1      current group is the final one
//  done_o   out  1      one-cycle pulse: operation complete
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; busy_o, valid_o, idx_o, mask_o, last_o, done_o = 0.
//  States: IDLE, RUN, DRAIN, DONE.
//   IDLE : start_i=1 -> latch vlen, idx=0; vlen=0 -> DONE, else -> RUN.
//   RUN  : valid_o = !stall_i (combinational). Issue = valid_o.
//          Issue & !last -> idx += LANES. Issue & last -> DRAIN (LAT=0 -> DONE).
//          stall_i=1: idx, mask, last hold; no issue.
//   DRAIN: counter counts LAT cycles, ignores stall_i; on expiry -> DONE.
//   DONE : done_o=1 for exactly this cycle -> IDLE.
//  start_i outside IDLE is ignored (not queued). vlen_i is ignored except at accept.
//  Arithmetic: idx+k and idx+LANES computed in IDX_W+1 bits; no wrap. last = (idx+LANES >= vlen).
//  mask_o, last_o: derived from registered idx and latched vlen; forced 0 outside RUN.
//  idx_o holds its last value in DRAIN/DONE/IDLE; reset to 0 on the next accepted start.
//  Latency: first issue on the cycle after start is accepted; done_o fires
//   LAT+1 cycles after the last issue cycle (vlen=0: done_o the cycle after accept).
//  Rst mid-operation: aborts at once, no done_o; after release, behaves as fresh IDLE.
// TESTING
//  1 vlen=10, no stall: issues idx 0,4,8; mask 1111,1111,0011; last on idx 8;
//    DRAIN 2 cycles; done_o 3 cycles after last issue; busy_o low the cycle after.
//  2 vlen=0: no valid_o ever; done_o exactly 1 cycle after start accepted.
//  3 vlen=10, stall_i high 3 cycles while idx=4: idx_o holds 4, valid_o=0, mask 1111;
//    resume issues 4 then 8; done_o 3 cycles later than case 1.
//  4 vlen=8, start_i pulsed again during RUN with vlen_i=3: ignored; groups 0,4 mask 1111,
//    last on idx 4; single done_o.
//  5 rst asserted asynchronously mid-RUN at idx=4: all outputs 0 before next edge, no done_o;
//    after release, start vlen=5 issues 0 (1111), 4 (0001 last).
//  6 vlen=255: last group idx 252 mask 0111, last_o=1, no index wrap, done_o follows.

Source files
------------

// File: rtl/vector_element_sequencer.sv
// vector_element_sequencer
// Steps an element-group index across a vector of vlen elements, LANES at a
// time. For each group it issues a tail-lane mask and flags the final group.
// After the final issue it waits out the datapath pipeline, then pulses done.
//
// Handshake: valid_o is the producer's valid and !stall_i is the consumer's
// ready. A group transfers on a cycle where valid_o=1. In RUN, valid_o is
// combinationally !stall_i, so a stalled cycle shows valid_o=0. During a stall,
// idx_o, mask_o and last_o are held steady. state_o exposes the FSM state.
module vector_element_sequencer #(
  parameter int IDX_W = 8,
  parameter int LANES = 4,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [IDX_W-1:0] vlen_i,
  input  logic             stall_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [LANES-1:0] mask_o,
  output logic             last_o,
  output logic             done_o,
  output logic [1:0]       state_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // The drain counter loads LAT-1 and expires at zero, so LAT cycles elapse in DRAIN.
  localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [1:0] S_AFTER_LAST = (LAT == 0) ? S_DONE : S_DRAIN;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] vlen_q, vlen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One extra bit keeps idx+LANES and idx+k free of wraparound near the top of the range.
  logic [IDX_W:0] idx_ext, vlen_ext, next_ext;
  logic           run, is_last, issue;

  // Derive group outputs from the registered index and the latched length.
  always_comb begin
    idx_ext  = {1'b0, idx_q};
    vlen_ext = {1'b0, vlen_q};
    next_ext = idx_ext + (IDX_W+1)'(LANES);
    run      = (state_q == S_RUN);
    is_last  = run && (next_ext >= vlen_ext);
    issue    = run && !stall_i;
    mask_o   = '0;
    for (int k = 0; k < LANES; k++) begin
      mask_o[k] = run && ((idx_ext + (IDX_W+1)'(k)) < vlen_ext);
    end
    busy_o  = (state_q != S_IDLE);
    valid_o = issue;
    idx_o   = idx_q;
    last_o  = is_last;
    done_o  = (state_q == S_DONE);
    state_o = state_q;
  end

  // Compute the next state: accept a start, step groups, drain the pipeline, then signal done.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vlen_d  = vlen_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d   = '0;
          vlen_d  = vlen_i;
          state_d = (vlen_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          if (is_last) begin
            state_d = S_AFTER_LAST;
            cnt_d   = CNT_INIT;
          end else begin
            idx_d = next_ext[IDX_W-1:0];
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Update registers; asserting rst aborts the operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vlen_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vlen_q  <= vlen_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
